// File: rtl/bus_io_responder_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and the STATUS packing
// helper for the bus I/O responder.
package bus_io_responder_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RSVD    = 2'd3
  } reg_idx_t;

  localparam int ST_RX_NE       = 0;
  localparam int ST_TX_NF       = 1;
  localparam int ST_TX_OVF      = 2;
  localparam int ST_TX_EMPTY    = 3;
  localparam int ST_RX_COUNT_LO = 4;
  localparam int ST_TX_COUNT_LO = 8;

  localparam int CTL_RXIE = 0;
  localparam int CTL_TXIE = 1;

  typedef struct packed {
    logic [2:0] tx_count;
    logic [2:0] rx_count;
    logic       tx_empty;
    logic       tx_ovf;
    logic       tx_nf;
    logic       rx_ne;
  } status_t;

  function automatic logic [15:0] pack_status(input status_t s);
    logic [15:0] v;
    v = '0;
    v[ST_RX_NE]              = s.rx_ne;
    v[ST_TX_NF]              = s.tx_nf;
    v[ST_TX_OVF]             = s.tx_ovf;
    v[ST_TX_EMPTY]           = s.tx_empty;
    v[ST_RX_COUNT_LO +: 3]   = s.rx_count;
    v[ST_TX_COUNT_LO +: 3]   = s.tx_count;
    return v;
  endfunction

endpackage

// File: rtl/bus_io_responder_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_io_responder.sv
// Memory-mapped bus target bridging CPU register accesses to a TX stream FIFO
// and an RX stream FIFO, with a registered level interrupt.
module bus_io_responder
  import bus_io_responder_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [15:0] DIN,
  input  logic        RDN,
  input  logic        WRN0,
  input  logic        WRN1,
  output logic [15:0] DOUT,
  output logic        DOUT_OEN,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  input  logic [15:0] RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        INT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic           sel;
  reg_idx_t       idx;
  logic           unused_addr0;

  logic           rdn_q;
  logic           wrn0_q;
  logic           wrn1_q;
  logic           rd_start;
  logic           rd_end;
  logic           wr_start;
  logic           rd_pop_armed;

  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;
  logic [CW-1:0]  tx_count;
  logic [15:0]    tx_head;
  logic [15:0]    tx_word;
  logic           tx_ovf;

  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic [CW-1:0]  rx_count;
  logic [15:0]    rx_head;

  logic           rxie;
  logic           txie;
  logic           int_q;
  status_t        st;
  logic [15:0]    read_word;

  assign sel          = (ADDR[15:3] == BASE[15:3]);
  assign idx          = reg_idx_t'(ADDR[2:1]);
  assign unused_addr0 = ADDR[0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdn_q  <= 1'b1;
      wrn0_q <= 1'b1;
      wrn1_q <= 1'b1;
    end else begin
      rdn_q  <= RDN;
      wrn0_q <= WRN0;
      wrn1_q <= WRN1;
    end
  end

  // A write access starts only when both strobes were idle last cycle, so a
  // late second byte strobe within the same access never acts again.
  assign wr_start = (!WRN0 || !WRN1) && wrn0_q && wrn1_q;
  assign rd_start = !RDN && rdn_q;
  assign rd_end   = RDN && !rdn_q;

  assign tx_word = {(WRN1 ? 8'h00 : DIN[15:8]), (WRN0 ? 8'h00 : DIN[7:0])};
  assign tx_push = wr_start && sel && (idx == REG_DATA);
  assign tx_pop  = !tx_empty && TX_READY;

  assign rx_push = RX_VALID && !rx_full;
  assign rx_pop  = rd_end && rd_pop_armed;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(16)) tx_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (tx_word),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(16)) rx_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (RX_DATA),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // The pop decision is latched when the read starts and applied when it ends.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_pop_armed <= 1'b0;
    end else if (rd_start) begin
      rd_pop_armed <= sel && (idx == REG_DATA) && !rx_empty;
    end else if (rd_end) begin
      rd_pop_armed <= 1'b0;
    end
  end

  // Overflow set wins over a same-cycle clear; only the low lane can clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_ovf <= 1'b0;
    end else if (tx_push && tx_full && !tx_pop) begin
      tx_ovf <= 1'b1;
    end else if (wr_start && sel && (idx == REG_STATUS) && !WRN0 && DIN[ST_TX_OVF]) begin
      tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxie <= 1'b0;
      txie <= 1'b0;
    end else if (wr_start && sel && (idx == REG_CONTROL) && !WRN0) begin
      rxie <= DIN[CTL_RXIE];
      txie <= DIN[CTL_TXIE];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      int_q <= 1'b0;
    end else begin
      int_q <= (rxie && !rx_empty) || (txie && tx_empty);
    end
  end

  always_comb begin
    st          = '0;
    st.rx_ne    = !rx_empty;
    st.tx_nf    = !tx_full;
    st.tx_ovf   = tx_ovf;
    st.tx_empty = tx_empty;
    st.rx_count = 3'(rx_count);
    st.tx_count = 3'(tx_count);
  end

  always_comb begin
    read_word = '0;
    case (idx)
      REG_DATA:    read_word = rx_empty ? 16'h0000 : rx_head;
      REG_STATUS:  read_word = pack_status(st);
      REG_CONTROL: read_word = {14'h0000, txie, rxie};
      default:     read_word = '0;
    endcase
  end

  assign DOUT_OEN = !(sel && !RDN);
  assign DOUT     = DOUT_OEN ? 16'h0000 : read_word;

  assign TX_DATA  = tx_head;
  assign TX_VALID = !tx_empty;
  assign RX_READY = !rx_full;
  assign INT      = int_q;

endmodule

// File: tb/tb_bus_io_responder.sv
// Directed self-checking bench for bus_io_responder: register map, TX/RX
// FIFO paths, overflow, strobe-event rules and interrupt timing.
module tb_bus_io_responder;

  localparam logic [15:0] A_DATA   = 16'hFF00;
  localparam logic [15:0] A_STATUS = 16'hFF02;
  localparam logic [15:0] A_CTRL   = 16'hFF04;
  localparam logic [15:0] A_RSVD   = 16'hFF06;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [15:0] din;
  logic        rdn;
  logic        wrn0;
  logic        wrn1;
  logic [15:0] dout;
  logic        dout_oen;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;
  logic [15:0] rd;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bus_io_responder #(.BASE(16'hFF00), .DEPTH(4)) dut (
    .CLK      (clk),
    .RESET    (reset_n),
    .ADDR     (addr),
    .DIN      (din),
    .RDN      (rdn),
    .WRN0     (wrn0),
    .WRN1     (wrn1),
    .DOUT     (dout),
    .DOUT_OEN (dout_oen),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .INT      (irq)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d,
                               input logic r, input logic w0, input logic w1);
    addr = a;
    din  = d;
    rdn  = r;
    wrn0 = w0;
    wrn1 = w1;
  endtask

  // One-cycle write access; lo/hi select which byte strobes go low.
  task automatic busWrite(input logic [15:0] a, input logic [15:0] d, input logic lo, input logic hi);
    applyStimulus(a, d, 1'b1, !lo, !hi);
    @(negedge clk);
    applyStimulus(a, d, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  // Read with RDN low for 'cycles' clocks; data sampled just before release.
  task automatic busRead(input logic [15:0] a, input int cycles, output logic [15:0] data);
    applyStimulus(a, 16'h0000, 1'b0, 1'b1, 1'b1);
    repeat (cycles) @(negedge clk);
    data = dout;
    applyStimulus(a, 16'h0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 16'h0000;
    rx_valid = 1'b0;
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    #12;
    checkOutput("rst_oen",      {15'd0, dout_oen}, 16'h0001);
    checkOutput("rst_dout",     dout,              16'h0000);
    checkOutput("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    checkOutput("rst_tx_data",  tx_data,           16'h0000);
    checkOutput("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
    checkOutput("rst_int",      {15'd0, irq},      16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    busRead(A_STATUS, 1, rd);
    checkOutput("rst_status", rd, 16'h000A);

    applyStimulus(A_STATUS, 16'h0000, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("sel_rd_oen", {15'd0, dout_oen}, 16'h0000);
    checkOutput("addr0_ignored", dout, 16'h000A);
    applyStimulus(16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("unsel_oen",  {15'd0, dout_oen}, 16'h0001);
    checkOutput("unsel_dout", dout,              16'h0000);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);

    busWrite(A_DATA, 16'h1234, 1'b1, 1'b1);
    checkOutput("tx_valid_1", {15'd0, tx_valid}, 16'h0001);
    checkOutput("tx_data_1",  tx_data,           16'h1234);
    busRead(A_STATUS, 1, rd);
    checkOutput("status_tx1", rd, 16'h0102);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checkOutput("tx_drained", {15'd0, tx_valid}, 16'h0000);

    for (int i = 1; i <= 5; i++) begin
      busWrite(A_DATA, 16'(i), 1'b1, 1'b1);
    end
    busRead(A_STATUS, 1, rd);
    checkOutput("status_ovf", rd, 16'h0404);
    checkOutput("tx_head_full", tx_data, 16'h0001);
    busWrite(A_STATUS, 16'h0004, 1'b1, 1'b0);
    busRead(A_STATUS, 1, rd);
    checkOutput("status_ovf_clr", rd, 16'h0400);

    applyStimulus(A_DATA, 16'h0005, 1'b1, 1'b0, 1'b0);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    applyStimulus(A_DATA, 16'h0005, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    busRead(A_STATUS, 1, rd);
    checkOutput("full_push_pop", rd, 16'h0400);
    tx_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checkOutput("tx_order", tx_data, 16'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checkOutput("tx_empty_end", {15'd0, tx_valid}, 16'h0000);

    busWrite(A_DATA, 16'hBEEF, 1'b0, 1'b1);
    checkOutput("hi_lane_only", tx_data, 16'hBE00);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;

    applyStimulus(A_DATA, 16'h1357, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(A_DATA, 16'h1357, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(A_DATA, 16'h1357, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    busRead(A_STATUS, 1, rd);
    checkOutput("stagger_one_push", rd, 16'h0102);
    checkOutput("stagger_data", tx_data, 16'h0057);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;

    rx_valid = 1'b1;
    rx_data  = 16'hAAAA;
    @(negedge clk);
    rx_data  = 16'h5555;
    @(negedge clk);
    rx_valid = 1'b0;
    busRead(A_STATUS, 1, rd);
    checkOutput("status_rx2", rd, 16'h002B);
    busRead(A_DATA, 3, rd);
    checkOutput("rx_read_1", rd, 16'hAAAA);
    busRead(A_STATUS, 1, rd);
    checkOutput("status_rx1", rd, 16'h001B);
    busRead(A_DATA, 3, rd);
    checkOutput("rx_read_2", rd, 16'h5555);
    busRead(A_DATA, 3, rd);
    checkOutput("rx_read_empty", rd, 16'h0000);
    busRead(A_STATUS, 1, rd);
    checkOutput("status_rx0", rd, 16'h000A);

    busWrite(A_CTRL, 16'hFF01, 1'b1, 1'b1);
    busRead(A_CTRL, 1, rd);
    checkOutput("ctrl_rxie", rd, 16'h0001);
    checkOutput("int_idle", {15'd0, irq}, 16'h0000);
    rx_valid = 1'b1;
    rx_data  = 16'h7777;
    @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("int_lag", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    checkOutput("int_rx_set", {15'd0, irq}, 16'h0001);
    busRead(A_DATA, 2, rd);
    checkOutput("rx_int_word", rd, 16'h7777);
    @(negedge clk);
    checkOutput("int_rx_clr", {15'd0, irq}, 16'h0000);

    busWrite(A_CTRL, 16'h0002, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("int_txie", {15'd0, irq}, 16'h0001);
    busWrite(A_RSVD, 16'hFFFF, 1'b1, 1'b1);
    busRead(A_RSVD, 1, rd);
    checkOutput("rsvd_read", rd, 16'h0000);
    busRead(A_CTRL, 1, rd);
    checkOutput("ctrl_after_rsvd", rd, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
